// File: rtl/pri_encoder_scan.sv
// Registered request-vector scanner.
// Captures a WIDTH-bit request vector and emits the index of every set bit,
// one per output handshake, in priority order (LSB-first or MSB-first).
// An all-zero vector produces a single beat flagged with out_none.
module pri_encoder_scan #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b0,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] encoder_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] binary_out,
    output logic             out_last,
    output logic             out_none
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] LSB_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Index of the highest-priority set bit; zero for an empty vector.
    // The loop direction makes the last matching bit win, which selects
    // the lowest bit for LSB-first and the highest bit for MSB-first.
    function automatic logic [IDX_W-1:0] pick_index(input logic [WIDTH-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) begin
                    idx = IDX_W'(i);
                end else begin
                    idx = idx;
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    idx = IDX_W'(i);
                end else begin
                    idx = idx;
                end
            end
        end
        return idx;
    endfunction

    // True when at most one bit is set: the beat built from this vector is
    // the final one (covers the all-zero single-beat case as well).
    function automatic logic is_final(input logic [WIDTH-1:0] vec);
        return ((vec & (vec - LSB_ONE)) == {WIDTH{1'b0}});
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pend_q, pend_d;
    logic               out_valid_q, out_valid_d;
    logic [IDX_W-1:0]   binary_out_q, binary_out_d;
    logic               out_last_q, out_last_d;
    logic               out_none_q, out_none_d;

    logic               out_fire_s;
    logic               in_fire_s;
    logic               in_ready_s;
    logic [WIDTH-1:0]   pend_rest_s;

    // Handshake qualifiers; a new vector may be taken on the final beat so
    // consecutive vectors stream without an idle cycle.
    always_comb begin
        out_fire_s  = out_valid_q & out_ready;
        in_ready_s  = enable
                    & ((state_q == ST_IDLE) | (out_fire_s & out_last_q))
                    & ~abort;
        in_fire_s   = in_valid & in_ready_s;
        pend_rest_s = pend_q & ~(LSB_ONE << binary_out_q);
    end

    // Next-state and next-output computation; abort wins over everything.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        out_valid_d  = out_valid_q;
        binary_out_d = binary_out_q;
        out_last_d   = out_last_q;
        out_none_d   = out_none_q;

        case (state_q)
            ST_IDLE: begin
                if (in_fire_s) begin
                    state_d      = ST_SCAN;
                    pend_d       = encoder_in;
                    out_valid_d  = 1'b1;
                    binary_out_d = pick_index(encoder_in);
                    out_last_d   = is_final(encoder_in);
                    out_none_d   = (encoder_in == {WIDTH{1'b0}});
                end else begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            ST_SCAN: begin
                if (out_fire_s && out_last_q) begin
                    if (in_fire_s) begin
                        state_d      = ST_SCAN;
                        pend_d       = encoder_in;
                        out_valid_d  = 1'b1;
                        binary_out_d = pick_index(encoder_in);
                        out_last_d   = is_final(encoder_in);
                        out_none_d   = (encoder_in == {WIDTH{1'b0}});
                    end else begin
                        state_d      = ST_IDLE;
                        pend_d       = {WIDTH{1'b0}};
                        out_valid_d  = 1'b0;
                        binary_out_d = {IDX_W{1'b0}};
                        out_last_d   = 1'b0;
                        out_none_d   = 1'b0;
                    end
                end else if (out_fire_s) begin
                    pend_d       = pend_rest_s;
                    binary_out_d = pick_index(pend_rest_s);
                    out_last_d   = is_final(pend_rest_s);
                    out_none_d   = 1'b0;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                pend_d       = {WIDTH{1'b0}};
                out_valid_d  = 1'b0;
                binary_out_d = {IDX_W{1'b0}};
                out_last_d   = 1'b0;
                out_none_d   = 1'b0;
            end
        endcase

        if (abort) begin
            state_d      = ST_IDLE;
            pend_d       = {WIDTH{1'b0}};
            out_valid_d  = 1'b0;
            binary_out_d = {IDX_W{1'b0}};
            out_last_d   = 1'b0;
            out_none_d   = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State, pending vector and registered output beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pend_q       <= {WIDTH{1'b0}};
            out_valid_q  <= 1'b0;
            binary_out_q <= {IDX_W{1'b0}};
            out_last_q   <= 1'b0;
            out_none_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            out_valid_q  <= out_valid_d;
            binary_out_q <= binary_out_d;
            out_last_q   <= out_last_d;
            out_none_q   <= out_none_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_q;
    assign binary_out = binary_out_q;
    assign out_last   = out_last_q;
    assign out_none   = out_none_q;

endmodule

// File: tb/tb_pri_encoder_scan.sv
// Bench for pri_encoder_scan: one LSB-first and one MSB-first instance share
// stimulus; each has its own queue of expected beats.
module tb_pri_encoder_scan;

    typedef struct packed {
        logic [3:0] idx;
        logic       last;
        logic       none;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] encoder_in = 16'h0000;
    logic        out_ready = 1'b1;

    logic        in_ready0, out_valid0, out_last0, out_none0;
    logic [3:0]  binary_out0;
    logic        in_ready1, out_valid1, out_last1, out_none1;
    logic [3:0]  binary_out1;

    beat_t sb0[$];
    beat_t sb1[$];

    int  n_checks = 0;
    int  n_errors = 0;
    bit  acc = 1'b0;
    bit  rand_ready = 1'b0;

    pri_encoder_scan #(.WIDTH(16), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .rst_n(rst_n), .enable(enable), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready0), .encoder_in(encoder_in),
        .out_valid(out_valid0), .out_ready(out_ready), .binary_out(binary_out0),
        .out_last(out_last0), .out_none(out_none0)
    );

    pri_encoder_scan #(.WIDTH(16), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .rst_n(rst_n), .enable(enable), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready1), .encoder_in(encoder_in),
        .out_valid(out_valid1), .out_ready(out_ready), .binary_out(binary_out1),
        .out_last(out_last1), .out_none(out_none1)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected beat lists for both priority orders, built bit by bit.
    task automatic push_vec(input logic [15:0] v);
        int n;
        int k;
        n = $countones(v);
        if (v == 16'h0000) begin
            sb0.push_back('{idx: 4'd0, last: 1'b1, none: 1'b1});
            sb1.push_back('{idx: 4'd0, last: 1'b1, none: 1'b1});
        end else begin
            k = 0;
            for (int i = 0; i < 16; i++) begin
                if (v[i]) begin
                    k++;
                    sb0.push_back('{idx: 4'(i), last: (k == n), none: 1'b0});
                end
            end
            k = 0;
            for (int i = 15; i >= 0; i--) begin
                if (v[i]) begin
                    k++;
                    sb1.push_back('{idx: 4'(i), last: (k == n), none: 1'b0});
                end
            end
        end
    endtask

    // One clock cycle: called just after a falling edge with inputs set.
    task automatic cycle();
        bit    fire;
        bit    exp_rdy;
        beat_t b;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        check_val("out_valid_lsb", out_valid0, sb0.size() != 0);
        check_val("out_valid_msb", out_valid1, sb1.size() != 0);
        fire = out_valid0 && out_ready;
        exp_rdy = enable && !abort && (sb0.size() == 0 || (fire && sb0.size() != 0 && sb0[0].last));
        check_val("in_ready_lsb", in_ready0, exp_rdy);
        check_val("in_ready_msb", in_ready1, exp_rdy);
        if (out_valid0 && sb0.size() != 0) begin
            b = sb0[0];
            check_val("idx_lsb", binary_out0, b.idx);
            check_val("last_lsb", out_last0, b.last);
            check_val("none_lsb", out_none0, b.none);
        end
        if (out_valid1 && sb1.size() != 0) begin
            b = sb1[0];
            check_val("idx_msb", binary_out1, b.idx);
            check_val("last_msb", out_last1, b.last);
            check_val("none_msb", out_none1, b.none);
        end
        acc = in_valid && in_ready0 && !abort;
        if (abort) begin
            sb0.delete();
            sb1.delete();
        end else begin
            if (fire && sb0.size() != 0) void'(sb0.pop_front());
            if (out_valid1 && out_ready && sb1.size() != 0) void'(sb1.pop_front());
            if (acc) push_vec(encoder_in);
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] v);
        int n;
        n = 0;
        in_valid = 1'b1;
        encoder_in = v;
        acc = 1'b0;
        while (!acc && n < 100) begin
            cycle();
            n++;
        end
        if (!acc) check_val("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb0.size() != 0 && n < 300) begin
            cycle();
            n++;
        end
        check_val("drain_timeout", sb0.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"}, {out_valid0, out_valid1}, 32'd0);
        check_val({tag, "_idx"}, {binary_out0, binary_out1}, 32'd0);
        check_val({tag, "_last"}, {out_last0, out_last1}, 32'd0);
        check_val({tag, "_none"}, {out_none0, out_none1}, 32'd0);
    endtask

    initial begin
        logic [15:0] v;
        #2;
        check_reset_outputs("reset");
        check_val("reset_in_ready", {in_ready0, in_ready1}, 32'd3);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // T1/T2: three beats, both orders
        send(16'h8012);
        drain();
        cycle();
        // T3: zero vector
        send(16'h0000);
        drain();
        cycle();
        // T4: stalled consumer holds the beat
        out_ready = 1'b0;
        send(16'h00F0);
        cycle();
        cycle();
        cycle();
        out_ready = 1'b1;
        drain();
        // T5: second vector taken on the final beat, no bubble
        send(16'h0101);
        send(16'h0001);
        drain();
        cycle();
        // Boundaries: single top bit, full vector
        send(16'h8000);
        send(16'hFFFF);
        drain();
        // enable dropped mid-scan: scan finishes, no new acceptance
        send(16'h0013);
        enable = 1'b0;
        in_valid = 1'b1;
        encoder_in = 16'h0002;
        drain();
        cycle();
        cycle();
        in_valid = 1'b0;
        enable = 1'b1;
        cycle();
        // T6: abort on the second beat
        send(16'hFFFF);
        cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        cycle();
        cycle();
        // Reset mid-scan clears outputs immediately
        send(16'hFFFF);
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb0.delete();
        sb1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        // Random traffic with a jittery consumer
        rand_ready = 1'b1;
        for (int r = 0; r < 30; r++) begin
            v = 16'($urandom) & 16'($urandom);
            if (r % 7 == 0) v = 16'h0000;
            send(v);
        end
        drain();
        rand_ready = 1'b0;
        out_ready = 1'b1;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
